// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : irq_pkg
// Purpose  : Shared FSM state encodings, line indices and ack/active codes
//            for the interrupt front end.
// Revision : 1.0 - initial release
// ============================================================================
package irq_pkg;

    // Front-end state: idle, presenting a frozen vector, post-ack holdoff
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESENT = 2'd1,
        S_HOLDOFF = 2'd2
    } irq_state_e;

    // Index of each line in irq_line / irq_pending / irq_mask
    localparam int IRQ0_IDX = 0;
    localparam int IRQ1_IDX = 1;

    // irq_active / irq_ack codes: bit 1 names IRQ0, bit 0 names IRQ1
    localparam logic [1:0] ACK_IRQ1 = 2'b01;
    localparam logic [1:0] ACK_IRQ0 = 2'b10;
    localparam logic [1:0] ACK_BOTH = 2'b11;

endpackage
`default_nettype wire

// File: rtl/irq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl_if
// Purpose  : Bundle of interrupt lines, CSR qualifiers and the ack/active
//            handshake between the interrupt front end and the control FSM.
//            master = CSR / control-FSM side, slave = irq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface irq_ctrl_if;

    logic [1:0] irq_line;
    logic [1:0] irq_mask;
    logic       irq_global_en;
    logic [1:0] irq_ack;
    logic [1:0] irq_active;
    logic [1:0] irq_pending;

    modport master (
        output irq_line,
        output irq_mask,
        output irq_global_en,
        output irq_ack,
        input  irq_active,
        input  irq_pending
    );

    modport slave (
        input  irq_line,
        input  irq_mask,
        input  irq_global_en,
        input  irq_ack,
        output irq_active,
        output irq_pending
    );

endinterface
`default_nettype wire

// File: rtl/irq_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : irq_sync_edge
// Purpose  : One interrupt line: optional synchroniser chain followed by
//            rising-edge or level detection, producing a set strobe for the
//            pending bit.
// Config   : IRQ_SYNC_EN defined   -> SYNC_STAGES-deep flop chain in front
//            IRQ_SYNC_EN undefined -> line used directly (clk-synchronous
//                                     on-chip sources only)
// Revision : 1.0 - initial release
// ============================================================================
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_TRIG   = 1'b1
) (
    input  wire clk,
    input  wire rst,
    input  wire line,
    output wire set_pulse
);

    if ((SYNC_STAGES < 2) || (SYNC_STAGES > 3)) begin : g_bad_sync_stages
        $error("irq_sync_edge: SYNC_STAGES must be 2 or 3");
    end

    logic line_s;

`ifdef IRQ_SYNC_EN
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // Shift the raw line one stage further into the synchroniser each cycle
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], line};
    end

    // Synchroniser chain register
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign line_s = sync_q[SYNC_STAGES-1];
`else
    assign line_s = line;
`endif

    if (EDGE_TRIG) begin : g_edge
        logic prev_q;
        logic prev_d;

        // Remember last cycle's conditioned line for edge detection
        always_comb begin
            prev_d = line_s;
        end

        // Edge register
        always_ff @(posedge clk) begin
            if (rst) begin
                prev_q <= 1'b0;
            end else begin
                prev_q <= prev_d;
            end
        end

        assign set_pulse = line_s & ~prev_q;
    end else begin : g_level
        assign set_pulse = line_s;
    end

endmodule
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl
// Purpose  : Interrupt front end for the core control FSM. Conditions two
//            interrupt lines, holds per-line pending bits, presents a frozen
//            irq_active vector and retires pending bits on irq_ack, followed
//            by a short holdoff so an ack cannot immediately re-trigger.
// Config   : IRQ_SYNC_EN - enables the per-line synchroniser chains.
// Revision : 1.0 - initial release
// ============================================================================
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_TRIG   = 1'b1,
    parameter int HOLDOFF     = 1
) (
    input  wire        clk,
    input  wire        s_reset_h,
    irq_ctrl_if.slave  bus
);

    if ((HOLDOFF < 1) || (HOLDOFF > 15)) begin : g_bad_holdoff
        $error("irq_ctrl: HOLDOFF must be in 1..15");
    end

    localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF - 1);

    logic [1:0] set_vec;
    logic [1:0] clr_vec;
    logic [1:0] req;
    logic [1:0] pending_q;
    logic [1:0] pending_d;
    logic [1:0] snap_q;
    logic [1:0] snap_d;
    logic [3:0] hold_q;
    logic [3:0] hold_d;
    irq_state_e state_q;
    irq_state_e state_d;

    for (genvar i = 0; i < 2; i++) begin : g_line
        irq_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES),
            .EDGE_TRIG   (EDGE_TRIG)
        ) u_sync_edge (
            .clk       (clk),
            .rst       (s_reset_h),
            .line      (bus.irq_line[i]),
            .set_pulse (set_vec[i])
        );
    end

    // A line may interrupt only when pending, individually and globally enabled
    assign req = pending_q & bus.irq_mask & {2{bus.irq_global_en}};

    // Next-state, snapshot and clear logic; the snapshot is the active vector
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        hold_d  = hold_q;
        clr_vec = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    // Active vector is bit-reversed relative to the line index
                    snap_d  = {req[IRQ0_IDX], req[IRQ1_IDX]};
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                // IRQ0 wins when both are acked; IRQ1 needs an exact 01 ack
                if (((bus.irq_ack & ACK_IRQ0) != 2'b00) && snap_q[1]) begin
                    clr_vec[IRQ0_IDX] = 1'b1;
                    snap_d[1]         = 1'b0;
                end else if ((bus.irq_ack == ACK_IRQ1) && snap_q[0]) begin
                    clr_vec[IRQ1_IDX] = 1'b1;
                    snap_d[0]         = 1'b0;
                end
                if (snap_d == 2'b00) begin
                    state_d = S_HOLDOFF;
                    hold_d  = HOLD_LOAD;
                end
            end
            S_HOLDOFF: begin
                if (hold_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                snap_d  = 2'b00;
            end
        endcase
    end

    // Pending bits: a new set beats a same-cycle clear so no edge is lost
    always_comb begin
        pending_d = set_vec | (pending_q & ~clr_vec);
    end

    // State, snapshot, holdoff counter and pending registers
    always_ff @(posedge clk) begin
        if (s_reset_h) begin
            state_q   <= S_IDLE;
            snap_q    <= 2'b00;
            hold_q    <= 4'd0;
            pending_q <= 2'b00;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            hold_q    <= hold_d;
            pending_q <= pending_d;
        end
    end

    assign bus.irq_active  = snap_q;
    assign bus.irq_pending = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_ctrl
// Purpose  : Directed testbench for irq_ctrl. Stimulus queues the expected
//            irq_active / irq_pending for a given clock edge; a monitor
//            checks each entry when that edge's outputs are visible.
// Config   : follows IRQ_SYNC_EN for the line-to-pending latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;
    import irq_pkg::*;

`ifdef IRQ_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    irq_ctrl_if bus ();

    irq_ctrl #(
        .SYNC_STAGES (2),
        .EDGE_TRIG   (1'b1),
        .HOLDOFF     (1)
    ) dut (
        .clk       (clk),
        .s_reset_h (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Edge counter: after edge n, cyc == n
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        string      name;
        logic [1:0] act;
        logic [1:0] pend;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_at(input int n, input string name,
                             input logic [1:0] act, input logic [1:0] pend);
        exp_t e;
        e.cyc  = n;
        e.name = name;
        e.act  = act;
        e.pend = pend;
        sb.push_back(e);
    endtask

    // Monitor: compare every queued expectation due at this edge
    always @(negedge clk) begin
        exp_t e;
        while ((sb.size() > 0) && (sb[0].cyc <= cyc)) begin
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: expectation for edge %0d not checked (now %0d)", e.name, e.cyc, cyc);
            end else begin
                checks++;
                if (bus.irq_active !== e.act) begin
                    errors++;
                    $display("FAIL %s irq_active @%0d: got %b want %b", e.name, cyc, bus.irq_active, e.act);
                end
                checks++;
                if (bus.irq_pending !== e.pend) begin
                    errors++;
                    $display("FAIL %s irq_pending @%0d: got %b want %b", e.name, cyc, bus.irq_pending, e.pend);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int n);
        int guard = 0;
        while ((cyc < n) && (guard < 1000)) begin
            step();
            guard++;
        end
    endtask

    initial begin
        int k;
        int m;
        int a;
        int r;
        int guard;

        rst               = 1'b1;
        bus.irq_line      = 2'b00;
        bus.irq_mask      = 2'b11;
        bus.irq_global_en = 1'b1;
        bus.irq_ack       = 2'b00;

        // Reset state
        expect_at(1, "reset1", 2'b00, 2'b00);
        expect_at(2, "reset2", 2'b00, 2'b00);
        wait_until(2);
        rst = 1'b0;

        // 1: single IRQ0 pulse, ack, one-cycle holdoff, idle
        k = cyc + 1;
        bus.irq_line = 2'b01;
        expect_at(k + LAT,     "s1_pend",    2'b00, 2'b01);
        expect_at(k + LAT + 1, "s1_active",  2'b10, 2'b01);
        expect_at(k + LAT + 2, "s1_holdoff", 2'b00, 2'b00);
        expect_at(k + LAT + 3, "s1_idle",    2'b00, 2'b00);
        expect_at(k + LAT + 4, "s1_quiet",   2'b00, 2'b00);
        step();
        bus.irq_line = 2'b00;
        wait_until(k + LAT + 1);
        bus.irq_ack = ACK_IRQ0;
        step();
        bus.irq_ack = 2'b00;
        wait_until(k + LAT + 4);

        // 2: both lines together, ack 11 retires IRQ0 only, then ack 01
        k = cyc + 1;
        bus.irq_line = 2'b11;
        expect_at(k + LAT,     "s2_pend",    2'b00, 2'b11);
        expect_at(k + LAT + 1, "s2_both",    2'b11, 2'b11);
        expect_at(k + LAT + 2, "s2_ack11",   2'b01, 2'b10);
        expect_at(k + LAT + 3, "s2_ack01",   2'b00, 2'b00);
        expect_at(k + LAT + 4, "s2_idle",    2'b00, 2'b00);
        step();
        bus.irq_line = 2'b00;
        wait_until(k + LAT + 1);
        bus.irq_ack = ACK_BOTH;
        step();
        bus.irq_ack = ACK_IRQ1;
        step();
        bus.irq_ack = 2'b00;
        wait_until(k + LAT + 4);

        // 3: IRQ1 masked stays pending only; unmask presents it; wrong ack ignored
        k = cyc + 1;
        bus.irq_mask = 2'b01;
        bus.irq_line = 2'b10;
        expect_at(k + LAT,     "s3_masked0", 2'b00, 2'b10);
        expect_at(k + LAT + 1, "s3_masked1", 2'b00, 2'b10);
        expect_at(k + LAT + 2, "s3_masked2", 2'b00, 2'b10);
        expect_at(k + LAT + 3, "s3_unmask",  2'b01, 2'b10);
        expect_at(k + LAT + 4, "s3_badack",  2'b01, 2'b10);
        expect_at(k + LAT + 5, "s3_ack",     2'b00, 2'b00);
        expect_at(k + LAT + 6, "s3_idle",    2'b00, 2'b00);
        step();
        bus.irq_line = 2'b00;
        wait_until(k + LAT + 2);
        bus.irq_mask = 2'b11;
        step();
        bus.irq_ack = ACK_IRQ0;
        step();
        bus.irq_ack = ACK_IRQ1;
        step();
        bus.irq_ack = 2'b00;
        wait_until(k + LAT + 6);

        // 4: frozen vector while global enable drops and IRQ1 arrives
        k = cyc + 1;
        m = k + 2 * LAT + 2;
        bus.irq_line = 2'b01;
        expect_at(k + LAT + 1, "s4_active",  2'b10, 2'b01);
        expect_at(m,           "s4_frozen",  2'b10, 2'b11);
        expect_at(m + 1,       "s4_holdoff", 2'b00, 2'b10);
        expect_at(m + 2,       "s4_gen_off", 2'b00, 2'b10);
        expect_at(m + 3,       "s4_gen_off2", 2'b00, 2'b10);
        expect_at(m + 4,       "s4_gen_on",  2'b01, 2'b10);
        expect_at(m + 5,       "s4_ack",     2'b00, 2'b00);
        expect_at(m + 6,       "s4_idle",    2'b00, 2'b00);
        step();
        bus.irq_line = 2'b00;
        wait_until(k + LAT + 1);
        bus.irq_global_en = 1'b0;
        bus.irq_line      = 2'b10;
        step();
        bus.irq_line = 2'b00;
        wait_until(m);
        bus.irq_ack = ACK_IRQ0;
        step();
        bus.irq_ack = 2'b00;
        wait_until(m + 3);
        bus.irq_global_en = 1'b1;
        step();
        bus.irq_ack = ACK_IRQ1;
        step();
        bus.irq_ack = 2'b00;
        wait_until(m + 6);

        // 5: new IRQ0 edge lands on the same edge as its ack
        k = cyc + 1;
        a = k + LAT + 3;
        expect_at(a - 1, "s5_active",   2'b10, 2'b01);
        expect_at(a,     "s5_set_wins", 2'b00, 2'b01);
        expect_at(a + 1, "s5_idle",     2'b00, 2'b01);
        expect_at(a + 2, "s5_repres",   2'b10, 2'b01);
        expect_at(a + 3, "s5_ack",      2'b00, 2'b00);
        expect_at(a + 4, "s5_idle2",    2'b00, 2'b00);
        for (int e = k; e <= a + 4; e++) begin
            bus.irq_line = ((e == k) || (e == k + 3)) ? 2'b01 : 2'b00;
            bus.irq_ack  = ((e == a) || (e == a + 3)) ? ACK_IRQ0 : 2'b00;
            step();
        end
        bus.irq_line = 2'b00;
        bus.irq_ack  = 2'b00;

        // 6: reset while both are active drops everything; ack afterwards ignored
        k = cyc + 1;
        r = k + LAT + 2;
        bus.irq_line = 2'b11;
        expect_at(k + LAT + 1, "s6_both",    2'b11, 2'b11);
        expect_at(r,           "s6_reset",   2'b00, 2'b00);
        expect_at(r + 1,       "s6_ack_ign", 2'b00, 2'b00);
        expect_at(r + 2,       "s6_quiet",   2'b00, 2'b00);
        step();
        bus.irq_line = 2'b00;
        wait_until(k + LAT + 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.irq_ack = ACK_BOTH;
        step();
        bus.irq_ack = 2'b00;
        wait_until(r + 2);

        // Drain the scoreboard with a bounded wait
        guard = 0;
        while ((sb.size() > 0) && (guard < 50)) begin
            step();
            guard++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
